// File: rtl/dcache_req_arb_pkg.sv
// Shared types and widths for the dcache request arbiter.
package dcache_req_arb_pkg;

    localparam int unsigned DC_INDEX_W   = 6;
    localparam int unsigned DC_TAG_W     = 20;
    localparam int unsigned DC_OFFSET_W  = 6;
    localparam int unsigned DC_WSTRB_W   = 4;
    localparam int unsigned STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_R0 = 1'b0,
        ARB_OWN_R1 = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic [1:0]             op;
        logic [DC_INDEX_W-1:0]  index;
        logic [DC_TAG_W-1:0]    tag;
        logic [DC_OFFSET_W-1:0] offset;
        logic [DC_WSTRB_W-1:0]  write_type;
        logic [31:0]            wdata;
    } dc_req_t;

endpackage

// File: rtl/dcache_req_arb_if.sv
// Requester, cache-port and status signals of the dcache request arbiter.
interface dcache_req_arb_if;
    import dcache_req_arb_pkg::*;

    logic                   flush;

    logic                   r0_valid;
    logic [1:0]             r0_op;
    logic [DC_INDEX_W-1:0]  r0_index;
    logic [DC_TAG_W-1:0]    r0_tag;
    logic [DC_OFFSET_W-1:0] r0_offset;
    logic [DC_WSTRB_W-1:0]  r0_write_type;
    logic [31:0]            r0_wdata;
    logic                   r0_addr_ok;
    logic                   r0_data_ok;
    logic [31:0]            r0_rdata;

    logic                   r1_valid;
    logic [1:0]             r1_op;
    logic [DC_INDEX_W-1:0]  r1_index;
    logic [DC_TAG_W-1:0]    r1_tag;
    logic [DC_OFFSET_W-1:0] r1_offset;
    logic [DC_WSTRB_W-1:0]  r1_write_type;
    logic [31:0]            r1_wdata;
    logic                   r1_addr_ok;
    logic                   r1_data_ok;
    logic [31:0]            r1_rdata;

    logic                   valid;
    logic [1:0]             op;
    logic [DC_INDEX_W-1:0]  index;
    logic [DC_TAG_W-1:0]    tag;
    logic [DC_OFFSET_W-1:0] offset;
    logic [DC_WSTRB_W-1:0]  write_type;
    logic [31:0]            w_data_CPU;
    logic                   addr_valid;
    logic                   data_valid;
    logic [31:0]            r_data_CPU;

    logic                   busy;

    modport slave (
        input  flush,
        input  r0_valid, r0_op, r0_index, r0_tag, r0_offset, r0_write_type, r0_wdata,
        output r0_addr_ok, r0_data_ok, r0_rdata,
        input  r1_valid, r1_op, r1_index, r1_tag, r1_offset, r1_write_type, r1_wdata,
        output r1_addr_ok, r1_data_ok, r1_rdata,
        output valid, op, index, tag, offset, write_type, w_data_CPU,
        input  addr_valid, data_valid, r_data_CPU,
        output busy
    );

    modport master (
        output flush,
        output r0_valid, r0_op, r0_index, r0_tag, r0_offset, r0_write_type, r0_wdata,
        input  r0_addr_ok, r0_data_ok, r0_rdata,
        output r1_valid, r1_op, r1_index, r1_tag, r1_offset, r1_write_type, r1_wdata,
        input  r1_addr_ok, r1_data_ok, r1_rdata,
        input  valid, op, index, tag, offset, write_type, w_data_CPU,
        output addr_valid, data_valid, r_data_CPU,
        input  busy
    );

endinterface

// File: rtl/dcache_req_arb_starve_cnt.sv
// Saturating count of requester-0 grants taken while requester 1 was waiting.
module arb_starve_cnt
    import dcache_req_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant0,
    input  logic grant1,
    input  logic r1_pending,
    output logic at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (grant1) begin
            cnt_d = '0;
        end else if (grant0) begin
            if (!r1_pending)
                cnt_d = '0;
            else if (cnt_q != LIM)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/dcache_req_arb.sv
// Two-requester arbiter/sequencer owning the single dcache request port.
module dcache_req_arb
    import dcache_req_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    dcache_req_arb_if.slave    bus_io
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    dc_req_t    req_q, req_d;

    logic cand0, pick1, grant0, grant1, at_limit;
    logic ack_addr, ack_data;

    arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .grant0     (grant0),
        .grant1     (grant1),
        .r1_pending (bus_io.r1_valid),
        .at_limit   (at_limit)
    );

    // Requester 1 overrides fixed priority once it has been passed over STARVE_LIMIT times.
    assign cand0 = bus_io.r0_valid & ~bus_io.flush;
    assign pick1 = bus_io.r1_valid & (at_limit | ~cand0);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        req_d    = req_q;
        grant0   = 1'b0;
        grant1   = 1'b0;
        ack_addr = 1'b0;
        ack_data = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick1) begin
                    grant1  = 1'b1;
                    owner_d = ARB_OWN_R1;
                    req_d   = '{op: bus_io.r1_op, index: bus_io.r1_index, tag: bus_io.r1_tag,
                                offset: bus_io.r1_offset, write_type: bus_io.r1_write_type,
                                wdata: bus_io.r1_wdata};
                    state_d = ARB_ADDR;
                end else if (cand0) begin
                    grant0  = 1'b1;
                    owner_d = ARB_OWN_R0;
                    req_d   = '{op: bus_io.r0_op, index: bus_io.r0_index, tag: bus_io.r0_tag,
                                offset: bus_io.r0_offset, write_type: bus_io.r0_write_type,
                                wdata: bus_io.r0_wdata};
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (bus_io.addr_valid) begin
                    ack_addr = 1'b1;
                    ack_data = bus_io.data_valid;
                    state_d  = bus_io.data_valid ? ARB_IDLE : ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (bus_io.data_valid) begin
                    ack_data = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWN_R0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
        end
    end

    assign bus_io.valid      = (state_q == ARB_ADDR);
    assign bus_io.busy       = (state_q != ARB_IDLE);
    assign bus_io.op         = req_q.op;
    assign bus_io.index      = req_q.index;
    assign bus_io.tag        = req_q.tag;
    assign bus_io.offset     = req_q.offset;
    assign bus_io.write_type = req_q.write_type;
    assign bus_io.w_data_CPU = req_q.wdata;

    assign bus_io.r0_addr_ok = ack_addr & (owner_q == ARB_OWN_R0);
    assign bus_io.r1_addr_ok = ack_addr & (owner_q == ARB_OWN_R1);
    assign bus_io.r0_data_ok = ack_data & (owner_q == ARB_OWN_R0);
    assign bus_io.r1_data_ok = ack_data & (owner_q == ARB_OWN_R1);
    assign bus_io.r0_rdata   = bus_io.r0_data_ok ? bus_io.r_data_CPU : '0;
    assign bus_io.r1_rdata   = bus_io.r1_data_ok ? bus_io.r_data_CPU : '0;

endmodule
